// File: rtl/exec_muldiv_seq_if.sv
// Request/response handshake bundle for the iterative RV32M multiply/divide sequencer.
// The execute stage drives it through the master modport; the sequencer uses the slave modport.
interface exec_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/exec_muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-cycle radix-2 shift-add multiply and restoring divide.
// Optional macro EXEC_MULDIV_EARLY_OUT_EN lets trivial MUL*/DIVU/REMU operands bypass the loop.
module exec_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  exec_muldiv_seq_if.slave   bus,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  op_e                 op;
  logic                a_neg;
  logic                b_neg;
  // Upper half: partial product / remainder. Lower half: multiplier / dividend-then-quotient.
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic [XLEN-1:0]     res_q;

  assign bus.in_ready  = (state == IDLE) & ~flush;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign busy          = (state != IDLE);

  // Operand capture at the accept edge
  op_e             op_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [XLEN-1:0] a_abs_in;
  logic [XLEN-1:0] b_abs_in;

  assign op_in    = op_e'(bus.funct3);
  assign a_neg_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & bus.op_a[XLEN-1];
  assign b_neg_in = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & bus.op_b[XLEN-1];
  assign a_abs_in = a_neg_in ? -bus.op_a : bus.op_a;
  assign b_abs_in = b_neg_in ? -bus.op_b : bus.op_b;

  logic            skip;
  logic [XLEN-1:0] skip_res;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    skip     = 1'b0;
    skip_res = '0;
    if (bus.funct3[2] && (bus.op_b == '0)) begin
      skip     = 1'b1;
      skip_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : bus.op_a;
    end else if ((op_in inside {OP_DIV, OP_REM}) &&
                 (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1)) begin
      skip     = 1'b1;
      skip_res = (op_in == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
    end else if (!bus.funct3[2] && ((bus.op_a == '0) || (bus.op_b == '0))) begin
      skip     = 1'b1;
      skip_res = '0;
    end else if ((op_in inside {OP_DIVU, OP_REMU}) && (bus.op_a < bus.op_b)) begin
      skip     = 1'b1;
      skip_res = (op_in == OP_DIVU) ? '0 : bus.op_a;
`endif
    end
  end

  // One loop iteration; the last one also feeds the sign-corrected result.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt   = {mul_sum, acc[XLEN-1:1]};
  // Partial remainder is always below the divisor, so bit XLEN of the difference is a clean borrow.
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_nxt   = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign acc_nxt   = op[2] ? div_nxt : mul_nxt;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin;

  assign prod_fix = (a_neg ^ b_neg) ? -acc_nxt : acc_nxt;
  assign quo_fix  = (a_neg ^ b_neg) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem_fix  = a_neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    fin = rem_fix;
    unique case (op)
      OP_MUL:                       fin = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin = quo_fix;
      default:                      fin = rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_MUL;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      acc   <= '0;
      opnd  <= '0;
      res_q <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op    <= op_in;
            a_neg <= a_neg_in;
            b_neg <= b_neg_in;
            acc   <= {{XLEN{1'b0}}, a_abs_in};
            opnd  <= b_abs_in;
            cnt   <= CNT_W'(XLEN - 1);
            if (skip) begin
              res_q <= skip_res;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q <= fin;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Self-checking bench for exec_muldiv_seq: directed RV32M vectors plus a latency/result model
// checked against the DUT handshake outputs on every cycle.
module tb_exec_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  exec_muldiv_seq_if #(.XLEN(32)) bus ();

  exec_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op, straight from the ISA definition.
  function automatic logic [31:0] exp_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accept edge to the first cycle with out_valid high.
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
    if (!f3[2] && (a == 0 || b == 0)) return 1;
    if ((f3 == 3'b101 || f3 == 3'b111) && a < b) return 1;
`endif
    return 33;
  endfunction

  // Model: one outstanding op, counting down to its result cycle.
  bit          m_active;
  int          m_left;
  logic [31:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_left   = 0;
      m_exp    = '0;
    end else if (flush) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_left == 0) begin
        if (bus.out_ready) m_active = 1'b0;
      end else begin
        m_left--;
      end
    end else if (bus.in_valid) begin
      m_active = 1'b1;
      m_left   = exp_lat(bus.funct3, bus.op_a, bus.op_b) - 1;
      m_exp    = exp_res(bus.funct3, bus.op_a, bus.op_b);
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cmp_in_ready", 32'(bus.in_ready), 32'(!m_active && !flush));
      check("cmp_out_valid", 32'(bus.out_valid), 32'(m_active && m_left == 0));
      check("cmp_busy", 32'(busy), 32'(m_active));
      if (m_active && m_left == 0) check("cmp_result", bus.result, m_exp);
    end
  end

  // Issue one op with out_ready high; called and returns at 1 ns after a rising edge in IDLE.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input int lat, input string name);
    int waited;
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.funct3   = ~f3;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.out_valid && waited < 100);
    check({name, "_lat"}, 32'(waited), 32'(lat));
    check(name, bus.result, lit);
    check({name, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'b000;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    do_op(3'b000, 32'd7,          32'd6,          32'd42,         33, "mul_7x6");
    do_op(3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33, "mulh_min");
    do_op(3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, "mulhsu_m1x2");
    do_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, "mulhu_max");
    do_op(3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, "mul_max");
    do_op(3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2");
    do_op(3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2");
    do_op(3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "div_7_m2");
    do_op(3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, "rem_7_m2");
    do_op(3'b101, 32'd100,        32'd7,          32'd14,         33, "divu_100_7");
    do_op(3'b111, 32'd100,        32'd7,          32'd2,          33, "remu_100_7");
    do_op(3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "div_by0");
    do_op(3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu_by0");
    do_op(3'b110, 32'd5,          32'd0,          32'd5,          1,  "rem_by0");
    do_op(3'b111, 32'd5,          32'd0,          32'd5,          1,  "remu_by0");
    do_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf");
    do_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf");
    do_op(3'b000, 32'd0,          32'd5,          32'd0,
          exp_lat(3'b000, 32'd0, 32'd5), "mul_zero");
    do_op(3'b101, 32'd3,          32'd10,         32'd0,
          exp_lat(3'b101, 32'd3, 32'd10), "divu_small");
    do_op(3'b111, 32'd3,          32'd10,         32'd3,
          exp_lat(3'b111, 32'd3, 32'd10), "remu_small");

    // Backpressure: result must hold while out_ready is low
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.funct3    = 3'b000;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.out_valid && waited < 100);
    check("bp_lat", 32'(waited), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", bus.result, 32'd15);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_after_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Flush in CALC cycle N+10 together with a new request
    bus.in_valid = 1'b1;
    bus.funct3   = 3'b101;
    bus.op_a     = 32'd1000;
    bus.op_b     = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.funct3   = 3'b000;
    bus.op_a     = 32'd2;
    bus.op_b     = 32'd2;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    check("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_result_kept", bus.result, 32'd15);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("flush_no_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC
    bus.in_valid = 1'b1;
    bus.funct3   = 3'b000;
    bus.op_a     = 32'd9;
    bus.op_b     = 32'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", bus.result, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_after_rst");

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_muldiv_seq.md
Name: exec_muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the single-cycle exec unit in the execute stage.
- Accepts one operation per valid/ready handshake and runs a radix-2 shift-add or restoring-divide loop for 32 cycles.
- Returns the 32-bit result on an output valid/ready handshake.
- Decode steers OP-opcode instructions with funct7 = 0000001 here. The pipeline stalls on `in_ready` / `out_valid`.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == XLEN.

Ports:
- clk  in  1  core clock; the block has one clock.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous abort of any in-flight or pending operation.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low, async): state = IDLE, counter = 0, all datapath registers = 0. Outputs: in_ready = 1, out_valid = 0, busy = 0, result = 0.
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE) & ~flush.
- out_valid = (state == DONE).
- busy = (state != IDLE).
- IDLE -> CALC on in_valid & in_ready. Latch funct3, the operand sign flags and the absolute values of the operands:
  - signed ops: MULH (both operands), MULHSU (op_a only), DIV/REM (both operands);
  - all other ops treat operands as unsigned;
  - counter = 31.
- Special cases on accept (IDLE -> DONE directly; result is valid the next cycle):
  - divide by zero (op_b == 0, ops 1xx): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - signed overflow (DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- CALC, one iteration per cycle:
  - multiply: shift-add over a 64-bit product register.
  - divide: restoring, one quotient bit per cycle.
  - counter decrements; on counter == 0 -> DONE.
- DONE entry: apply sign correction.
  - product is negated if the sign flags differ (MULH/MULHSU).
  - quotient is negated if the dividend and divisor signs differ.
  - remainder takes the sign of the dividend.
  - Select the output word: MUL -> low 32 bits; MULH/MULHSU/MULHU -> high 32 bits; DIV/DIVU -> quotient; REM/REMU -> remainder.
- Latency:
  - handshake at edge N; CALC occupies cycles N+1..N+32; out_valid is first high in cycle N+33.
  - special-case ops: out_valid first high in cycle N+1.
- DONE holds result stable while out_valid & ~out_ready. DONE -> IDLE on out_ready; in_ready goes high the following cycle, so there is no same-cycle re-accept.
- flush: from any state, next state = IDLE and out_valid = 0.
  - flush wins over a simultaneous out_ready or in_valid; that request is not accepted and the pending result is discarded.
  - result keeps its last value.
- in_valid is ignored while not in IDLE. Inputs are sampled only at the accept edge; later changes to them have no effect.
- rst_n asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: EXEC_MULDIV_EARLY_OUT_EN.
- Defined:
  - MUL* ops with op_a == 0 or op_b == 0 skip CALC: IDLE -> DONE, result = 0, out_valid in cycle N+1.
  - DIVU/REMU with op_a < op_b skip CALC: quotient 0, remainder op_a, out_valid in cycle N+1.
- Undefined: these cases take the full 33-cycle path with identical results.
- Results are bit-identical either way; only latency differs.

Test Plan:
- MUL, op_a = 7, op_b = 6, out_ready = 1 -> out_valid first in cycle N+33, result = 42, busy high N+1..N+33.
- MULH, op_a = 0x80000000, op_b = 0x80000000 -> result = 0x40000000. MULHSU, op_a = 0xFFFFFFFF, op_b = 2 -> result = 0xFFFFFFFF.
- DIV, op_a = -7 (0xFFFFFFF9), op_b = 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, op_a = 100, op_b = 7 -> 14.
- DIV by zero, op_a = 5, op_b = 0 -> 0xFFFFFFFF in cycle N+1. REMU same operands -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> result and out_valid stable, in_ready = 0. Release -> in_ready = 1 the following cycle.
- flush asserted in CALC cycle N+10 together with in_valid = 1 -> IDLE next cycle, out_valid never rises, new request not accepted. Async rst_n pulse mid-CALC -> all outputs at reset values immediately.
